// File: rtl/actel_counter_if.sv
// actel_counter_if - control and status bundle between the loop controller
// and the Actel counter.
interface actel_counter_if #(
    parameter int WIDTH = 5
);
    logic             ld;
    logic             en;
    logic             clr_ovf;
    logic [WIDTH-1:0] init;
    logic [WIDTH-1:0] cnt;
    logic             co;
    logic             ovf;

    // Controller side: issues load/enable/clear and watches the count.
    modport master (
        output ld, en, clr_ovf, init,
        input  cnt, co, ovf
    );

    // Counter side.
    modport slave (
        input  ld, en, clr_ovf, init,
        output cnt, co, ovf
    );
endinterface

// File: rtl/actel_counter.sv
// actel_counter - loadable, enable-gated up-counter with terminal count and
// sticky overflow, assembled from Actel S2 (sequential) and C1/C2
// (combinational) cell models. Only the S2 cell model contains a clocked
// process; the counter itself is pure cell instantiation.

// Actel S2: 4:1 data mux in front of a flop with asynchronous clear.
// Select encoding: {s1,s0} = 00 -> d00, 01 -> d01, 10 -> d10, 11 -> d11.
module actel_s2 (
    input  logic clk,
    input  logic i_clr,
    input  logic i_s0,
    input  logic i_s1,
    input  logic i_d00,
    input  logic i_d01,
    input  logic i_d10,
    input  logic i_d11,
    output logic o_q
);
    logic w_d;
    logic r_q;

    assign w_d = i_s1 ? (i_s0 ? i_d11 : i_d10) : (i_s0 ? i_d01 : i_d00);
    assign o_q = r_q;

    // Capture the selected data input; CLR overrides the clock at any time.
    always_ff @(posedge clk or posedge i_clr) begin
        // NOTE: non-blocking so every flop samples pre-edge values of its neighbours.
        if (i_clr) begin
            r_q <= 1'b0;
        end else begin
            r_q <= w_d;
        end
    end
endmodule

// Actel C1: 2-input AND.
module actel_c1 (
    input  logic i_a,
    input  logic i_b,
    output logic o_y
);
    assign o_y = i_a & i_b;
endmodule

// Actel C2: 2-input AND with inverted B input.
module actel_c2 (
    input  logic i_a,
    input  logic i_b,
    output logic o_y
);
    assign o_y = i_a & ~i_b;
endmodule

// Counter top. Legal WIDTH range is 2..16.
module actel_counter #(
    parameter int WIDTH = 5
) (
    input  logic            clk,
    input  logic            rst,
    actel_counter_if.slave  bus
);
    logic [WIDTH-1:0] w_cnt;
    logic             w_co;
    logic             w_ovf;

    // Per bit: the ripple-carry term decides whether the bit toggles. The S2
    // select pair is {ld, toggle}, so ld picks init (d10/d11), otherwise
    // toggle picks ~cnt (d01) or the held cnt (d00). init only reaches D when
    // ld is high, and all four data legs are always driven.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic w_tgl;    // bit i toggles: en & AND(cnt[i-1:0])
        logic w_carry;  // w_tgl & cnt[i], the toggle term of bit i+1
        logic w_q_n;

        if (i == 0) begin : g_lsb
            assign w_tgl = bus.en;
        end else begin : g_upper
            assign w_tgl = g_bit[i-1].w_carry;
        end

        actel_c1 u_carry (
            .i_a (w_tgl),
            .i_b (w_cnt[i]),
            .o_y (w_carry)
        );

        actel_c2 u_inv (
            .i_a (1'b1),
            .i_b (w_cnt[i]),
            .o_y (w_q_n)
        );

        actel_s2 u_ff (
            .clk   (clk),
            .i_clr (rst),
            .i_s0  (w_tgl),
            .i_s1  (bus.ld),
            .i_d00 (w_cnt[i]),
            .i_d01 (w_q_n),
            .i_d10 (bus.init[i]),
            .i_d11 (bus.init[i]),
            .o_q   (w_cnt[i])
        );
    end

    // Terminal count reuses the last carry: en & all-ones, suppressed by ld.
    // This is also the wrap event that sets ovf.
    actel_c2 u_co (
        .i_a (g_bit[WIDTH-1].w_carry),
        .i_b (bus.ld),
        .o_y (w_co)
    );

    // Sticky overflow: select {wrap, clr_ovf}. Wrap selects constant 1 on
    // both d1x legs so a coincident clear loses; clear alone selects 0;
    // otherwise the flag recirculates.
    actel_s2 u_ovf (
        .clk   (clk),
        .i_clr (rst),
        .i_s0  (bus.clr_ovf),
        .i_s1  (w_co),
        .i_d00 (w_ovf),
        .i_d01 (1'b0),
        .i_d10 (1'b1),
        .i_d11 (1'b1),
        .o_q   (w_ovf)
    );

    assign bus.cnt = w_cnt;
    assign bus.co  = w_co;
    assign bus.ovf = w_ovf;
endmodule

// File: tb/tb_actel_counter.sv
// tb_actel_counter - directed checks of actel_counter at WIDTH 5, plus
// free-running sweeps at WIDTH 2 and 8 against a behavioural model.
module tb_actel_counter;
    logic clk = 1'b0;
    logic rst5;
    logic rst2;
    logic rst8;

    int n_assert = 0;
    int n_fail   = 0;

    int m_cnt;
    int m_ovf;
    int pulses;

    always #5 clk = ~clk;

    actel_counter_if #(.WIDTH(5)) bus5 ();
    actel_counter_if #(.WIDTH(2)) bus2 ();
    actel_counter_if #(.WIDTH(8)) bus8 ();

    actel_counter #(.WIDTH(5)) dut5 (.clk(clk), .rst(rst5), .bus(bus5));
    actel_counter #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst2), .bus(bus2));
    actel_counter #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst8), .bus(bus8));

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and let outputs settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- WIDTH = 5 directed sequence ----------------
        rst5 = 1'b1; bus5.ld = 1'b1; bus5.en = 1'b1; bus5.clr_ovf = 1'b0; bus5.init = 5'h1A;
        rst2 = 1'b1; bus2.ld = 1'b0; bus2.en = 1'b0; bus2.clr_ovf = 1'b0; bus2.init = 2'h0;
        rst8 = 1'b1; bus8.ld = 1'b0; bus8.en = 1'b0; bus8.clr_ovf = 1'b0; bus8.init = 8'h00;

        // Reset dominates load and enable across edges.
        tick();
        tick();
        check("rst_cnt", 16'(bus5.cnt), 16'h0);
        check("rst_ovf", 16'(bus5.ovf), 16'h0);
        check("rst_co", 16'(bus5.co), 16'h0);
        bus5.ld = 1'b0;
        #1;
        check("rst_co_en", 16'(bus5.co), 16'h0);

        @(negedge clk);
        rst5 = 1'b0;
        tick();
        check("first_inc", 16'(bus5.cnt), 16'h01);

        // Load then count up to terminal count.
        bus5.ld = 1'b1; bus5.init = 5'h1C;
        tick();
        check("load_1c", 16'(bus5.cnt), 16'h1C);
        bus5.ld = 1'b0; bus5.en = 1'b1;
        #1;
        check("co_at_1c", 16'(bus5.co), 16'h0);
        tick();
        check("cnt_1d", 16'(bus5.cnt), 16'h1D);
        tick();
        check("cnt_1e", 16'(bus5.cnt), 16'h1E);
        check("co_at_1e", 16'(bus5.co), 16'h0);
        tick();
        check("cnt_1f", 16'(bus5.cnt), 16'h1F);
        check("co_at_1f", 16'(bus5.co), 16'h1);
        check("ovf_pre_wrap", 16'(bus5.ovf), 16'h0);
        bus5.en = 1'b0;
        #1;
        check("co_1f_en0", 16'(bus5.co), 16'h0);
        bus5.en = 1'b1;
        #1;
        check("co_1f_en1", 16'(bus5.co), 16'h1);

        // Wrap sets ovf; it sticks while idle; clr_ovf clears it.
        tick();
        check("wrap_cnt", 16'(bus5.cnt), 16'h00);
        check("wrap_ovf", 16'(bus5.ovf), 16'h1);
        check("wrap_co", 16'(bus5.co), 16'h0);
        bus5.en = 1'b0;
        repeat (5) tick();
        check("idle_cnt", 16'(bus5.cnt), 16'h00);
        check("idle_ovf", 16'(bus5.ovf), 16'h1);
        bus5.clr_ovf = 1'b1;
        tick();
        check("clr_ovf", 16'(bus5.ovf), 16'h0);
        bus5.clr_ovf = 1'b0;

        // Load beats enable at 1F: no wrap, ovf untouched, co low.
        bus5.ld = 1'b1; bus5.init = 5'h1F;
        tick();
        check("load_1f", 16'(bus5.cnt), 16'h1F);
        bus5.init = 5'h03; bus5.en = 1'b1;
        #1;
        check("co_ld_prio", 16'(bus5.co), 16'h0);
        tick();
        check("ld_prio_cnt", 16'(bus5.cnt), 16'h03);
        check("ld_prio_ovf", 16'(bus5.ovf), 16'h0);

        // Clear coincident with wrap: set wins.
        bus5.init = 5'h1F;
        tick();
        bus5.ld = 1'b0; bus5.en = 1'b1; bus5.clr_ovf = 1'b1;
        #1;
        check("co_clr_wrap", 16'(bus5.co), 16'h1);
        tick();
        check("clr_wrap_cnt", 16'(bus5.cnt), 16'h00);
        check("clr_wrap_ovf", 16'(bus5.ovf), 16'h1);
        bus5.clr_ovf = 1'b0;

        // A load leaves a set ovf alone.
        bus5.ld = 1'b1; bus5.init = 5'h05; bus5.en = 1'b0;
        tick();
        check("load_05", 16'(bus5.cnt), 16'h05);
        check("load_keeps_ovf", 16'(bus5.ovf), 16'h1);

        // Hold with init undefined: init is ignored when ld is low.
        bus5.ld = 1'b0; bus5.init = 'x;
        tick();
        tick();
        check("hold_x_init", 16'(bus5.cnt), 16'h05);

        // Async reset between edges while counting at 0B.
        bus5.ld = 1'b1; bus5.init = 5'h0A;
        tick();
        bus5.ld = 1'b0; bus5.en = 1'b1;
        tick();
        check("cnt_0b", 16'(bus5.cnt), 16'h0B);
        #2;
        rst5 = 1'b1;
        #1;
        check("async_cnt", 16'(bus5.cnt), 16'h00);
        check("async_ovf", 16'(bus5.ovf), 16'h0);
        check("async_co", 16'(bus5.co), 16'h0);
        @(negedge clk);
        rst5 = 1'b0;
        tick();
        check("resume_1", 16'(bus5.cnt), 16'h01);
        tick();
        check("resume_2", 16'(bus5.cnt), 16'h02);

        // ---------------- WIDTH = 2 free run ----------------
        bus2.en = 1'b1;
        @(negedge clk);
        rst2 = 1'b0;
        m_cnt = 0; m_ovf = 0; pulses = 0;
        for (int k = 0; k < 5; k++) begin
            check("w2_co", 16'(bus2.co), 16'(m_cnt == 3));
            if (bus2.co) pulses++;
            tick();
            if (m_cnt == 3) m_ovf = 1;
            m_cnt = (m_cnt + 1) % 4;
            check("w2_cnt", 16'(bus2.cnt), 16'(m_cnt));
            check("w2_ovf", 16'(bus2.ovf), 16'(m_ovf));
        end
        check("w2_end_cnt", 16'(bus2.cnt), 16'h1);
        check("w2_end_ovf", 16'(bus2.ovf), 16'h1);
        check("w2_pulses", 16'(pulses), 16'h1);

        // ---------------- WIDTH = 8 free run ----------------
        bus8.en = 1'b1;
        @(negedge clk);
        rst8 = 1'b0;
        m_cnt = 0; m_ovf = 0; pulses = 0;
        for (int k = 0; k < 257; k++) begin
            check("w8_co", 16'(bus8.co), 16'(m_cnt == 255));
            if (bus8.co) pulses++;
            tick();
            if (m_cnt == 255) m_ovf = 1;
            m_cnt = (m_cnt + 1) % 256;
            check("w8_cnt", 16'(bus8.cnt), 16'(m_cnt));
            check("w8_ovf", 16'(bus8.ovf), 16'(m_ovf));
        end
        check("w8_end_cnt", 16'(bus8.cnt), 16'h1);
        check("w8_end_ovf", 16'(bus8.ovf), 16'h1);
        check("w8_pulses", 16'(pulses), 16'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
